// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, PC step, instruction
// field positions and the opcodes the control unit also decodes.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam int PC_STEP    = 4;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, keeps at most one instruction-memory read in
// flight, buffers one instruction for decode and applies jump / taken-bne redirects.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [5:0]        Opcode,
  output logic [5:0]        Function,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  output fetch_state_e      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never drops before its transfer except on a redirect.

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              req_fire;
  logic              inst_fire;

  assign redirect       = Jump | (Branch & ~Zero);
  assign target         = Jump ? jump_target : branch_target;
  // Gated by reset so no request is advertised while reset is held.
  assign imem_req_valid = (state_q == REQ) & ~reset;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign inst_fire      = inst_valid_q & inst_ready & ~redirect;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign Opcode     = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign Function   = inst_q[FUNCT_MSB:FUNCT_LSB];
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      REQ: begin
        if (redirect) pc_d = target;
        if (req_fire) state_d = redirect ? FLUSH : WAIT;
      end
      WAIT: begin
        // A redirect wins over a same-cycle response; that data is dropped.
        if (redirect) begin
          pc_d    = target;
          state_d = FLUSH;
        end else if (imem_rsp_valid) begin
          inst_d       = imem_rsp_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          inst_valid_d = 1'b0;
          pc_d         = target;
          state_d      = REQ;
        end else if (inst_fire) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + ADDR_W'(PC_STEP);
          state_d      = REQ;
        end
      end
      FLUSH: begin
        // Waiting for the orphaned response of a cancelled fetch.
        if (redirect) pc_d = target;
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end for the single-issue MIPS-subset core.
- Owns the PC and issues one-outstanding read requests to instruction memory.
- Buffers one returned instruction and presents it, with Opcode/Function fields, to the decode/control stage over a valid/ready handshake.
- Applies Jump and taken-bne redirects from the control/ALU side and discards any in-flight fetch.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  fetch address (= pc)
- imem_rsp_valid  in  1  read data valid; one pulse per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  buffered instruction valid toward decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  buffered instruction word
- inst_pc  out  ADDR_W  address of buffered instruction
- Opcode  out  6  inst[31:26]
- Function  out  6  inst[5:0]
- Branch  in  1  bne decoded (from control)
- Zero  in  1  ALU zero flag
- Jump  in  1  j decoded (from control)
- branch_target  in  ADDR_W  bne target
- jump_target  in  ADDR_W  j target

Behaviour:
- Clock, reset and polarity are fixed: single clock clk; reset is asynchronous, active-high.
- Reset values: pc=RESET_PC, state=REQ, imem_req_valid=0 during reset, inst_valid=0, inst=0, inst_pc=0, Opcode=0, Function=0.
- Redirect definition:
  - redirect = Jump | (Branch & ~Zero).
  - target = Jump ? jump_target : branch_target; Jump has priority.
- Accept conditions:
  - req_fire = imem_req_valid & imem_req_ready.
  - inst_fire = inst_valid & inst_ready & ~redirect.
  - Redirect beats consumption: no delay slot, and the held instruction is discarded.
- States: REQ, WAIT, HOLD, FLUSH (2-bit encoding).
- REQ:
  - imem_req_valid=1, addr=pc.
  - req_fire & ~redirect -> WAIT.
  - req_fire & redirect -> pc<=target, FLUSH.
  - ~req_fire & redirect -> pc<=target, stay in REQ. This is the only case where the address changes while valid is high.
- WAIT:
  - imem_req_valid=0.
  - redirect -> pc<=target, FLUSH; this applies even if rsp_valid is high in the same cycle, and that data is dropped.
  - rsp_valid -> inst<=imem_rsp_data, inst_pc<=pc, inst_valid<=1, HOLD.
- HOLD:
  - inst_valid=1; inst, Opcode and Function are stable.
  - redirect -> inst_valid<=0, pc<=target, REQ.
  - inst_fire -> inst_valid<=0, pc<=pc+4 (mod 2^ADDR_W, wraps silently), REQ.
  - Otherwise hold.
- FLUSH:
  - Waits for the orphaned response; imem_req_valid=0.
  - rsp_valid -> data discarded, REQ.
  - A further redirect updates pc and stays in FLUSH, or goes to REQ if rsp_valid is high in the same cycle.
- Latency:
  - Request accepted in cycle N, response in N+k; inst_valid is high in N+k+1.
  - After inst_fire, the next request is visible in the next cycle.
  - Steady-state best throughput is 1 instruction per 3 cycles.
- Opcode and Function are combinational slices of the inst register (registered source, glitch-free).
- Reset asserted mid-operation: all state clears immediately. Any response that arrives after reset release, before the first new request is accepted, is ignored because state is REQ.
- Never more than one outstanding request.
- imem_rsp_valid while in REQ or HOLD is a protocol error; it is ignored and there is no state change.

Decomposition:
- Shared package fetch_pkg:
  - state enum {REQ, WAIT, HOLD, FLUSH}
  - PC_STEP=4
  - OPCODE_MSB=31, OPCODE_LSB=26, FUNCT_MSB=5, FUNCT_LSB=0
  - opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_BNE=6'b000101, shared with the control unit
- Single module, no sub-module. The next-PC mux (pc+4 / branch_target / jump_target) may be a small function in the package.

Test Plan:
- Reset release, memory always ready, latency 1, words 0x00000020 at 0x0, 0x8C010004 at 0x4, inst_ready=1 -> requests at addr 0x0 then 0x4; inst=0x00000020 with Opcode=0, Function=0x20, inst_pc=0; then Opcode=0x23, inst_pc=4.
- inst_ready held 0 for 5 cycles in HOLD -> inst, inst_pc and inst_valid stable; no new request issued; pc advances by 4 only after inst_ready rises.
- Jump=1, jump_target=0x40 while in WAIT, response arriving 2 cycles later -> response discarded; inst_valid stays 0; next request addr=0x40.
- In HOLD: Branch=1, Zero=0, branch_target=0x100, inst_ready=1 in the same cycle -> instruction not consumed; next request addr=0x100. Repeating with Zero=1 -> normal consumption, next addr=pc+4.
- Jump=1 and taken bne in the same cycle (jump_target=0x80, branch_target=0xC0) -> next request addr=0x80.
- RESET_PC=32'hFFFF_FFFC -> second request addr=0x00000000 (wrap). Reset asserted in WAIT with a response pending -> outputs return to reset values asynchronously; first post-reset request addr=RESET_PC; the stale response is ignored.
